// File: rtl/fdct4_serial.sv
// Forward 4-point DCT: collects 4 samples, butterfly then multiply stage, output row held until out_ready (2 cycles after 4th accept).
// in_ready only in COLLECT; define FDCT4_SAT_EN to saturate coefficients instead of wrapping them.
module fdct4_serial #(
  parameter int DATA_W = 25,
  parameter int SHIFT  = 8,
  parameter int INT_W  = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] d_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] c_out_0,
  output logic signed [DATA_W-1:0] c_out_1,
  output logic signed [DATA_W-1:0] c_out_2,
  output logic signed [DATA_W-1:0] c_out_3,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic [1:0] {COLLECT, BFLY, MULT, HOLD} state_t;

  localparam logic signed [INT_W-1:0] C64  = INT_W'(64);
  localparam logic signed [INT_W-1:0] C83  = INT_W'(83);
  localparam logic signed [INT_W-1:0] C36  = INT_W'(36);
  localparam logic signed [INT_W-1:0] RND  = INT_W'(1) << (SHIFT - 1);
  localparam logic signed [INT_W-1:0] MAXV = (INT_W'(1) << (DATA_W - 1)) - INT_W'(1);
  localparam logic signed [INT_W-1:0] MINV = -(INT_W'(1) << (DATA_W - 1));

  state_t state, state_nxt;
  logic [1:0] cnt;
  logic signed [DATA_W-1:0] x [4];
  logic signed [INT_W-1:0] e0, e1, o0, o1;
  logic signed [INT_W-1:0] y0, y1, y2, y3;

  // Round half up via arithmetic shift, then fit into DATA_W.
  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [INT_W-1:0] y);
    logic signed [INT_W-1:0] r;
    r = (y + RND) >>> SHIFT;
`ifdef FDCT4_SAT_EN
    if (r > MAXV)
      return MAXV[DATA_W-1:0];
    else if (r < MINV)
      return MINV[DATA_W-1:0];
    else
      return r[DATA_W-1:0];
`else
    return r[DATA_W-1:0];
`endif
  endfunction

  assign y0 = C64 * e0 + C64 * e1;
  assign y2 = C64 * e0 - C64 * e1;
  assign y1 = C83 * o0 + C36 * o1;
  assign y3 = C36 * o0 - C83 * o1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= COLLECT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && cnt == 2'd3)
          state_nxt = BFLY;
      end
      BFLY:    state_nxt = MULT;
      MULT:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 2'd0;
      for (int i = 0; i < 4; i++)
        x[i] <= '0;
      e0        <= '0;
      e1        <= '0;
      o0        <= '0;
      o1        <= '0;
      c_out_0   <= '0;
      c_out_1   <= '0;
      c_out_2   <= '0;
      c_out_3   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        x[cnt] <= d_in;
        cnt    <= cnt + 2'd1;
      end
      if (state == BFLY) begin
        e0 <= INT_W'(x[0]) + INT_W'(x[3]);
        e1 <= INT_W'(x[1]) + INT_W'(x[2]);
        o0 <= INT_W'(x[0]) - INT_W'(x[3]);
        o1 <= INT_W'(x[1]) - INT_W'(x[2]);
      end
      if (state == MULT) begin
        c_out_0   <= reduce(y0);
        c_out_1   <= reduce(y1);
        c_out_2   <= reduce(y2);
        c_out_3   <= reduce(y3);
        out_valid <= 1'b1;
      end
      // Coefficients stay put after the row is taken; only the flag drops.
      if (state == HOLD && out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fdct4_serial.sv
// Scoreboard bench for fdct4_serial: SHIFT=8 instance for functional/random rows, SHIFT=1 instance for overflow.
module tb_fdct4_serial;
  localparam int DW = 25;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic signed [DW-1:0] d8, d1, c8_0, c8_1, c8_2, c8_3, c1_0, c1_1, c1_2, c1_3;
  logic iv8, iv1, ir8, ir1, ov8, ov1, or8, or1;

  fdct4_serial #(.DATA_W(DW), .SHIFT(8), .INT_W(36)) u8 (
    .clk(clk), .reset(reset), .d_in(d8), .in_valid(iv8), .in_ready(ir8),
    .c_out_0(c8_0), .c_out_1(c8_1), .c_out_2(c8_2), .c_out_3(c8_3),
    .out_valid(ov8), .out_ready(or8));

  fdct4_serial #(.DATA_W(DW), .SHIFT(1), .INT_W(36)) u1 (
    .clk(clk), .reset(reset), .d_in(d1), .in_valid(iv1), .in_ready(ir1),
    .c_out_0(c1_0), .c_out_1(c1_1), .c_out_2(c1_2), .c_out_3(c1_3),
    .out_valid(ov1), .out_ready(or1));

  int n_cmp = 0;
  int n_err = 0;
  longint q8[$];
  longint q1[$];
  int row8[$];
  int row1[$];
  bit rnd_ordy = 1'b0;

  // DCT-II basis rows scaled by 64 (matrix form of the transform).
  int coef [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                      '{64, -64, -64, 64}, '{36, -83, 83, -36}};

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint fit(input longint y, input int sh);
    longint r;
    r = (y + (longint'(1) << (sh - 1))) >>> sh;
`ifdef FDCT4_SAT_EN
    if (r > (longint'(1) << (DW - 1)) - 1) r = (longint'(1) << (DW - 1)) - 1;
    if (r < -(longint'(1) << (DW - 1)))    r = -(longint'(1) << (DW - 1));
`else
    r = r & ((longint'(1) << DW) - 1);
    if (r >= (longint'(1) << (DW - 1))) r = r - (longint'(1) << DW);
`endif
    return r;
  endfunction

  task automatic model_row(input int which);
    longint y;
    for (int k = 0; k < 4; k++) begin
      y = 0;
      for (int n = 0; n < 4; n++)
        y += longint'(coef[k][n]) * longint'(which == 0 ? row8[n] : row1[n]);
      if (which == 0) q8.push_back(fit(y, 8));
      else            q1.push_back(fit(y, 1));
    end
    if (which == 0) row8.delete();
    else            row1.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ordy) or8 = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input int which, input int v);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    if (which == 0) begin d8 = DW'(v); iv8 = 1'b1; end
    else            begin d1 = DW'(v); iv1 = 1'b1; end
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = (which == 0) ? ir8 : ir1;
      tick();
      t++;
    end
    iv8 = 1'b0;
    iv1 = 1'b0;
    check("accept", longint'(acc), 1);
    if (acc) begin
      if (which == 0) begin
        row8.push_back(v);
        if (row8.size() == 4) model_row(0);
      end else begin
        row1.push_back(v);
        if (row1.size() == 4) model_row(1);
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q8.size() != 0 || q1.size() != 0) && t < 300) begin
      tick();
      t++;
    end
    check("drain", longint'(q8.size() + q1.size()), 0);
  endtask

  // Monitors: compare each accepted output row against the scoreboard.
  initial forever begin
    longint got [4];
    @(negedge clk);
    if (!reset && ov8 && or8) begin
      got = '{c8_0, c8_1, c8_2, c8_3};
      if (q8.size() < 4) check("u8_unexpected_row", longint'(q8.size()), 4);
      else for (int k = 0; k < 4; k++) check($sformatf("u8_c%0d", k), got[k], q8.pop_front());
    end
  end

  initial forever begin
    longint got [4];
    @(negedge clk);
    if (!reset && ov1 && or1) begin
      got = '{c1_0, c1_1, c1_2, c1_3};
      if (q1.size() < 4) check("u1_unexpected_row", longint'(q1.size()), 4);
      else for (int k = 0; k < 4; k++) check($sformatf("u1_c%0d", k), got[k], q1.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [DW-1:0] s;
    d8 = '0; d1 = '0; iv8 = 1'b0; iv1 = 1'b0; or8 = 1'b1; or1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(ov8), 0);
    check("rst_in_ready", longint'(ir8), 1);
    check("rst_c0", c8_0, 0);
    check("rst_c3", c8_3, 0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", longint'(ir8), 1);

    // Ones row with latency and backpressure checks.
    or8 = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 1);
    check("lat_edge_n", longint'(ov8), 0);
    tick();
    check("lat_edge_n1", longint'(ov8), 0);
    tick();
    check("lat_edge_n2", longint'(ov8), 1);
    iv8 = 1'b1;
    d8 = DW'(99);
    for (int i = 0; i < 5; i++) begin
      check("hold_in_ready", longint'(ir8), 0);
      check("hold_valid", longint'(ov8), 1);
      check("hold_c0", c8_0, 1);
      check("hold_c1", c8_1, 0);
      tick();
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    tick();
    check("release_valid", longint'(ov8), 0);
    check("release_in_ready", longint'(ir8), 1);
    check("kept_c0", c8_0, 1);

    // Odd terms and negative rounding.
    push(0, 100); push(0, 0); push(0, 0); push(0, -100);
    for (int i = 0; i < 4; i++) push(0, -1);
    drain();

    // Reset in the middle of a row.
    push(0, 7); push(0, 7);
    tick();
    reset = 1'b1;
    #1;
    check("midrst_valid", longint'(ov8), 0);
    check("midrst_in_ready", longint'(ir8), 1);
    check("midrst_c0", c8_0, 0);
    tick();
    check("midrst_valid_hold", longint'(ov8), 0);
    reset = 1'b0;
    row8.delete();
    for (int i = 0; i < 4; i++) push(0, 1);
    drain();

    // Random rows with random output backpressure and input gaps.
    rnd_ordy = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 0) push(0, int'($urandom_range(0, 2000)) - 1000);
        else begin
          s = DW'($urandom);
          push(0, int'(s));
        end
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    drain();
    rnd_ordy = 1'b0;
    or8 = 1'b1;

    // Overflow at SHIFT=1.
    for (int i = 0; i < 4; i++) push(1, 1 << 20);
    drain();

    check("q8_empty", longint'(q8.size()), 0);
    check("q1_empty", longint'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
